// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: stall vector bit positions, the NOP encoding and
// the fetch-response tracking states used by the IF/ID stage.
package cpu_defs_pkg;

  localparam int STALL_PC = 0;
  localparam int STALL_IF = 1;
  localparam int STALL_ID = 2;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    EMPTY,
    LIVE,
    HELD
  } if_state_t;

endpackage

// File: rtl/if_id_stage_if.sv
// Instruction SRAM port: the fetch stage is the master that drives enable and
// address, and the memory returns read data one cycle later.
interface if_id_stage_if;

  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;

  modport master (
    output inst_sram_en,
    output inst_sram_addr,
    input  inst_sram_rdata
  );

  modport slave (
    input  inst_sram_en,
    input  inst_sram_addr,
    output inst_sram_rdata
  );

endinterface

// File: rtl/if_hold_buf.sv
// Fetch-response tracker: pairs late SRAM data with its PC and keeps one
// instruction alive while IF is stalled (EMPTY / LIVE / HELD).
module if_hold_buf
  import cpu_defs_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        stall_if,
  input  logic        issue,
  input  logic [31:0] req_pc,
  input  logic        req_adel,
  input  logic [31:0] rdata,
  output logic        dlv_v,
  output logic [31:0] dlv_pc,
  output logic [31:0] dlv_inst,
  output logic        dlv_adel
);

  if_state_t   state_q, state_d;
  logic [31:0] resp_pc_q;
  logic        resp_adel_q;
  logic [31:0] hold_pc_q, hold_inst_q;
  logic        hold_adel_q;
  logic [31:0] resp_inst;

  // A misaligned slot never touched the SRAM, so its data is meaningless.
  assign resp_inst = resp_adel_q ? NOP_INST : rdata;

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      EMPTY:   state_d = issue ? LIVE : EMPTY;
      LIVE:    state_d = stall_if ? HELD : (issue ? LIVE : EMPTY);
      HELD:    state_d = stall_if ? HELD : (issue ? LIVE : EMPTY);
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q     <= EMPTY;
      resp_pc_q   <= '0;
      resp_adel_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        resp_pc_q   <= req_pc;
        resp_adel_q <= req_adel;
      end
    end
  end

  // NOTE: hold data is not reset; it is only observed when state_q == HELD.
  always_ff @(posedge clk) begin
    if (state_q == LIVE && stall_if) begin
      hold_pc_q   <= resp_pc_q;
      hold_inst_q <= resp_inst;
      hold_adel_q <= resp_adel_q;
    end
  end

  assign dlv_v    = (state_q == LIVE) || (state_q == HELD);
  assign dlv_pc   = (state_q == HELD) ? hold_pc_q   : resp_pc_q;
  assign dlv_inst = (state_q == HELD) ? hold_inst_q : resp_inst;
  assign dlv_adel = (state_q == HELD) ? hold_adel_q : resp_adel_q;

endmodule

// File: rtl/if_id_stage.sv
// IF/ID stage: drives the instruction SRAM from pc_i and registers PC/inst into ID.
// Optional fetch alignment check enabled by defining IF_ADEL_CHECK_EN.
module if_id_stage
  import cpu_defs_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          pc_i,
  input  logic                 ce_i,
  input  logic [5:0]           stall,
  input  logic                 flush,
  if_id_stage_if.master        sram,
  output logic [31:0]          id_pc,
  output logic [31:0]          id_inst,
  output logic                 id_valid,
  output logic                 id_excp_adel
);

  logic        issue;
  logic        fetch_adel;
  logic        dlv_v;
  logic [31:0] dlv_pc, dlv_inst;
  logic        dlv_adel;
  logic        unused_stall;

  assign unused_stall = ^{stall[5:3], stall[STALL_PC]};

  // A slot is tracked even when the alignment check keeps the SRAM idle.
  assign issue = ce_i & ~stall[STALL_IF] & ~flush;

`ifdef IF_ADEL_CHECK_EN
  assign fetch_adel = (pc_i[1:0] != 2'b00);
`else
  assign fetch_adel = 1'b0;
`endif

  assign sram.inst_sram_en   = issue & ~fetch_adel;
  assign sram.inst_sram_addr = pc_i;

  if_hold_buf u_hold_buf (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .stall_if (stall[STALL_IF]),
    .issue    (issue),
    .req_pc   (pc_i),
    .req_adel (fetch_adel),
    .rdata    (sram.inst_sram_rdata),
    .dlv_v    (dlv_v),
    .dlv_pc   (dlv_pc),
    .dlv_inst (dlv_inst),
    .dlv_adel (dlv_adel)
  );

  // Flush outranks every stall; a bubble keeps the previous PC.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      id_pc        <= RESET_PC;
      id_inst      <= NOP_INST;
      id_valid     <= 1'b0;
      id_excp_adel <= 1'b0;
    end else if (!stall[STALL_ID]) begin
      if (!stall[STALL_IF] && dlv_v) begin
        id_pc        <= dlv_pc;
        id_inst      <= dlv_inst;
        id_valid     <= 1'b1;
        id_excp_adel <= dlv_adel;
      end else begin
        id_inst      <= NOP_INST;
        id_valid     <= 1'b0;
        id_excp_adel <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: issued fetches go into a scoreboard
// queue and are popped when the behavioural model says ID loads them.
module tb_if_id_stage;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } fetch_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        ce_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] id_pc, id_inst;
  logic        id_valid, id_excp_adel;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_t sb[$];
  fetch_t exp_id;
  logic   exp_valid;

  if_id_stage_if sram ();

  if_id_stage #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_i),
    .ce_i         (ce_i),
    .stall        (stall),
    .flush        (flush),
    .sram         (sram),
    .id_pc        (id_pc),
    .id_inst      (id_inst),
    .id_valid     (id_valid),
    .id_excp_adel (id_excp_adel)
  );

  always #5 clk = ~clk;

  // SRAM model: mem[a] = a + 0x100; output is garbage when not enabled.
  always @(posedge clk)
    sram.inst_sram_rdata <= sram.inst_sram_en ? sram.inst_sram_addr + 32'h100 : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic fetch_t model_fetch(input logic [31:0] pc);
    fetch_t f;
    f.pc   = pc;
    f.inst = pc + 32'h100;
    f.adel = 1'b0;
`ifdef IF_ADEL_CHECK_EN
    if (pc[1:0] != 2'b00) begin
      f.inst = 32'h0;
      f.adel = 1'b1;
    end
`endif
    return f;
  endfunction

  // One clock: drive inputs, check SRAM request, advance model, check ID.
  task automatic cycle(input logic ce, input logic [31:0] pc, input logic [5:0] st,
                       input logic fl, input logic r);
    fetch_t f;
    logic   issued;
    ce_i  = ce;
    pc_i  = pc;
    stall = st;
    flush = fl;
    rst   = r;
    f      = model_fetch(pc);
    issued = ce & ~st[1] & ~fl;
    #1;
    check("sram_en", {31'b0, sram.inst_sram_en}, {31'b0, issued & ~f.adel});
    if (issued) check("sram_addr", sram.inst_sram_addr, pc);
    @(posedge clk);
    if (r || fl) begin
      sb.delete();
      exp_id    = '{pc: RESET_PC, inst: 32'h0, adel: 1'b0};
      exp_valid = 1'b0;
    end else if (!st[2]) begin
      if (!st[1] && sb.size() > 0) begin
        exp_id    = sb.pop_front();
        exp_valid = 1'b1;
      end else begin
        exp_id.inst = 32'h0;
        exp_id.adel = 1'b0;
        exp_valid   = 1'b0;
      end
    end
    if (issued && !r) sb.push_back(f);
    #1;
    check("id_valid", {31'b0, id_valid}, {31'b0, exp_valid});
    check("id_pc", id_pc, exp_id.pc);
    check("id_inst", id_inst, exp_id.inst);
    check("id_excp_adel", {31'b0, id_excp_adel}, {31'b0, exp_id.adel});
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rpc;
    logic [5:0]  rst_st;
    logic        rfl, rce;
    rst = 1'b1; ce_i = 1'b0; pc_i = '0; stall = '0; flush = 1'b0;
    exp_id    = '{pc: RESET_PC, inst: 32'h0, adel: 1'b0};
    exp_valid = 1'b0;
    @(negedge clk);

    // Reset, then one idle cycle with ce_i low.
    cycle(1'b0, 32'h0, 6'b0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 6'b0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 6'b0, 1'b0, 1'b0);

    // Streaming at one instruction per cycle.
    for (int a = 0; a <= 32'h10; a += 4) cycle(1'b1, a, 6'b0, 1'b0, 1'b0);

    // IF+PC stall for 3 cycles with 0x10 in flight, then release.
    repeat (3) cycle(1'b1, 32'h14, 6'b000011, 1'b0, 1'b0);
    cycle(1'b1, 32'h14, 6'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h18, 6'b0, 1'b0, 1'b0);

    // ID holds 0x20 while 0x24 is held in the buffer.
    cycle(1'b1, 32'h1c, 6'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h20, 6'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h24, 6'b0, 1'b0, 1'b0);
    repeat (2) cycle(1'b1, 32'h28, 6'b000111, 1'b0, 1'b0);
    cycle(1'b1, 32'h28, 6'b0, 1'b0, 1'b0);

    // Flush while 0x28 response is live: 0x28 must never reach ID.
    cycle(1'b1, 32'h2c, 6'b0, 1'b1, 1'b0);
    cycle(1'b1, 32'h2c, 6'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h30, 6'b0, 1'b0, 1'b0);

    // Flush while HELD, with the stall still asserted.
    cycle(1'b1, 32'h34, 6'b000011, 1'b0, 1'b0);
    cycle(1'b1, 32'h34, 6'b000011, 1'b1, 1'b0);
    cycle(1'b1, 32'h34, 6'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h38, 6'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h3c, 6'b0, 1'b0, 1'b0);

    // Reset during HELD; nothing stale may appear afterwards.
    cycle(1'b1, 32'h40, 6'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h44, 6'b000011, 1'b0, 1'b0);
    cycle(1'b0, 32'h44, 6'b000011, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 6'b0, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 32'h0, 6'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h44, 6'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h48, 6'b0, 1'b0, 1'b0);

`ifdef IF_ADEL_CHECK_EN
    // Misaligned fetches, one delivered directly and one via the hold buffer.
    cycle(1'b1, 32'h32, 6'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h4c, 6'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h36, 6'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h50, 6'b000011, 1'b0, 1'b0);
    cycle(1'b1, 32'h50, 6'b0, 1'b0, 1'b0);
`endif

    // Random stalls, flushes and fetch gaps.
    rpc = 32'h100;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 7))
        5:       rst_st = 6'b000011;
        6:       rst_st = 6'b000111;
        7:       rst_st = 6'b001111;
        default: rst_st = 6'b000000;
      endcase
      rfl = ($urandom_range(0, 19) == 0);
      rce = ($urandom_range(0, 9) != 0);
      cycle(rce, rpc, rst_st, rfl, 1'b0);
      if (rce && !rst_st[1] && !rfl) rpc += 4;
    end

    repeat (4) cycle(1'b0, 32'h0, 6'b0, 1'b0, 1'b0);
    check("sb_drain", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

Fetch-response and IF/ID pipeline stage of the MIPS core. Sits directly downstream of the PC register. Drives the instruction SRAM request from the incoming PC, pairs the one-cycle-late SRAM read data with the PC that requested it, and registers the pair into the ID stage. A one-entry hold buffer keeps the fetched instruction alive across pipeline stalls, because the SRAM enable drops while IF is stalled.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, value of id_pc after reset or flush

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- pc_i  in  32  fetch address from PC register
- ce_i  in  1  fetch enable from PC register (0 during and one cycle after reset)
- stall  in  6  pipeline stall vector; bit1 = IF, bit2 = ID; prefix-monotonic
- flush  in  1  kill all in-flight fetch state
- inst_sram_en  out  1  SRAM read enable
- inst_sram_addr  out  32  SRAM address, equals pc_i
- inst_sram_rdata  in  32  SRAM data, valid the cycle after the request
- id_pc  out  32  PC of the instruction in ID
- id_inst  out  32  instruction in ID
- id_valid  out  1  ID holds a real instruction
- id_excp_adel  out  1  fetch address-error flag

## Operation
- inst_sram_en = ce_i & ~stall[1] & ~flush.
  - With IF_ADEL_CHECK_EN defined, also gated by pc_i[1:0]==0.
- Request tracking: at every edge where a request issues, resp_pc_q<=pc_i. At every edge, resp_v_q<=(request issued).
- States:
  - EMPTY: no instruction pending.
  - LIVE: resp_v_q=1; the instruction is on inst_sram_rdata.
  - HELD: the instruction is in hold_inst_q/hold_pc_q.
- LIVE, stall[1]=0: ID loads {resp_pc_q, rdata, valid=1}. Next state is LIVE if a new request issued, otherwise EMPTY.
- LIVE, stall[1]=1: hold regs capture {resp_pc_q, rdata}; next state HELD.
- HELD, stall[1]=1: hold contents unchanged.
- HELD, stall[1]=0: ID loads from hold regs; next state is LIVE if a request issued this cycle, otherwise EMPTY.
- EMPTY, stall[1]=0: ID loads a bubble (valid=0, inst=0, pc unchanged).
- ID register update rules:
  - stall[1]=1, stall[2]=0: bubble into ID.
  - stall[2]=1: ID holds.
- Flush has priority over every stall condition:
  - id_valid<=0, id_inst<=0, id_excp_adel<=0, id_pc<=RESET_PC.
  - State goes to EMPTY; resp_v_q<=0.
  - inst_sram_en is low in the flush cycle.
- Simultaneous flush and a returning response: the response is discarded.

## Timing
- Reset values: id_pc=RESET_PC, id_inst=0, id_valid=0, id_excp_adel=0, state EMPTY, resp_v_q=0, inst_sram_en=0 (ce_i is 0).
- Latency: pc_i presented in cycle N; rdata arrives in N+1; id_* are valid in N+2. With no stalls, throughput is one instruction per cycle.
- Stall released in cycle M: the held instruction appears on id_* in M+1. The next instruction follows back-to-back.
- Reset asserted mid-stall or mid-HELD: all state returns to reset values on the next edge.

## Configuration
- IF_ADEL_CHECK_EN defined:
  - pc_i[1:0]!=0 suppresses inst_sram_en, but the slot is still tracked.
  - At delivery, id_inst=0, id_excp_adel=1, id_valid=1.
  - The flag is stored in the hold buffer alongside the instruction.
- IF_ADEL_CHECK_EN undefined: no alignment check; id_excp_adel is tied 0.

## Structure
- Shared package cpu_defs_pkg:
  - stall bit indices STALL_PC=0, STALL_IF=1, STALL_ID=2
  - NOP_INST=32'h0
  - typedef if_state_t {EMPTY, LIVE, HELD}
- Sub-module if_hold_buf: holds the state register, hold registers and the LIVE/HELD/EMPTY transition logic. The top level keeps the SRAM drive and the ID register.

## Test plan
- Reset released; stream PCs 0,4,8 with mem[a]=a+32'h100 -> id_inst 32'h100, 32'h104, 32'h108 on consecutive cycles; id_valid=1 from the third cycle after ce_i rises.
- PC=0x10 in flight; stall[1:0]=2'b11, stall[2]=0 for 3 cycles -> inst_sram_en=0, ID shows bubbles; on release id_pc=0x10 with the original data, then 0x14 next cycle.
- stall[2:0]=3'b111 for 2 cycles while ID holds PC 0x20 -> id_* stay constant; the held 0x24 enters ID one cycle after release.
- flush asserted in the same cycle as a LIVE response and while HELD -> id_valid=0, id_pc=RESET_PC; the discarded PC never reaches ID.
- IF_ADEL_CHECK_EN defined, pc_i=0x32 -> inst_sram_en=0; two cycles later id_excp_adel=1, id_inst=0, id_pc=0x32.
- rst asserted during HELD -> all outputs return to reset values the next cycle; no stale instruction appears after rst deasserts.
